// File: rtl/mem_bus_initiator_if.sv
// mem_bus_initiator_if
// Groups the sequencer request/response handshake and the memory bus signals
// of the relay computer's memory initiator.
//   Request  : req_valid, req_write, req_addr[15:0], req_wdata[7:0] -> req_ready
//   Response : rsp_valid (one-cycle pulse), rsp_rdata[7:0]
//   Memory   : bus_addr[15:0], mem_read, mem_write, bus_wdata[7:0],
//              bus_wdata_oe, bus_rdata[7:0]
//   Status   : busy
// master  = the initiator itself; slave = sequencer + memory side.
interface mem_bus_initiator_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] bus_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  bus_wdata;
    logic        bus_wdata_oe;
    logic [7:0]  bus_rdata;
    logic        busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, bus_addr, mem_read,
               mem_write, bus_wdata, bus_wdata_oe, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, bus_addr, mem_read,
               mem_write, bus_wdata, bus_wdata_oe, busy
    );
endinterface

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator
// Runs one memory bus cycle per accepted request, with relay-style timing:
// SETUP_CYC cycles of address/data setup, STROBE_CYC cycles of mem_read or
// mem_write, HOLD_CYC cycles of hold, then a single DONE cycle that pulses
// rsp_valid. Read data is captured on the last strobe cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mem_bus_initiator_if.master (request, response and memory bus)
module mem_bus_initiator #(
    parameter int unsigned SETUP_CYC  = 1,  // 1..15
    parameter int unsigned STROBE_CYC = 2,  // 1..15
    parameter int unsigned HOLD_CYC   = 1   // 0..15
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_bus_initiator_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        oe_q, oe_d;
    logic        rsp_valid_q, rsp_valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(SETUP_CYC - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'(STROBE_CYC - 1);
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Memory still drives the data bus on the last strobe cycle.
                    if (!write_q) begin
                        rdata_d = bus.bus_rdata;
                    end
                    if (HOLD_CYC == 0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = 4'(HOLD_CYC - 1);
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completed write reports zero read data.
        if ((state_d == DONE) && (state_q != DONE) && write_q) begin
            rdata_d = '0;
        end

        // Strobes, oe and rsp_valid are flops decoded from the next state so
        // they switch cleanly on the clock edge and drop on async reset.
        mem_read_d  = (state_d == STROBE) && !write_d;
        mem_write_d = (state_d == STROBE) && write_d;
        oe_d        = write_d && ((state_d == SETUP) || (state_d == STROBE) ||
                                  (state_d == HOLD));
        rsp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.bus_addr     = addr_q;
    assign bus.bus_wdata    = wdata_q;
    assign bus.bus_wdata_oe = oe_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;

    a_no_dual_strobe: assert property (
        @(posedge clk) disable iff (reset) !(mem_read_q && mem_write_q)
    );

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator
// Drives two initiators (default timing, and HOLD_CYC = 0) through one shared
// set of stimulus variables selected by 'sel', with a byte memory on the bus
// and a transaction-level reference memory for expected read data.
module tb_mem_bus_initiator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    mem_bus_initiator_if if0();
    mem_bus_initiator_if if1();

    mem_bus_initiator #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    mem_bus_initiator #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(0)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    logic        sel = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_write = 1'b0;
    logic [15:0] t_addr = '0;
    logic [7:0]  t_wdata = '0;

    assign if0.req_valid = t_valid & ~sel;
    assign if1.req_valid = t_valid & sel;
    assign if0.req_write = t_write;
    assign if1.req_write = t_write;
    assign if0.req_addr  = t_addr;
    assign if1.req_addr  = t_addr;
    assign if0.req_wdata = t_wdata;
    assign if1.req_wdata = t_wdata;

    logic        o_ready, o_rv, o_rd, o_wr, o_oe, o_busy;
    logic [7:0]  o_rdata, o_wdata;
    logic [15:0] o_addr;
    assign o_ready = sel ? if1.req_ready    : if0.req_ready;
    assign o_rv    = sel ? if1.rsp_valid    : if0.rsp_valid;
    assign o_rd    = sel ? if1.mem_read     : if0.mem_read;
    assign o_wr    = sel ? if1.mem_write    : if0.mem_write;
    assign o_oe    = sel ? if1.bus_wdata_oe : if0.bus_wdata_oe;
    assign o_busy  = sel ? if1.busy         : if0.busy;
    assign o_rdata = sel ? if1.rsp_rdata    : if0.rsp_rdata;
    assign o_wdata = sel ? if1.bus_wdata    : if0.bus_wdata;
    assign o_addr  = sel ? if1.bus_addr     : if0.bus_addr;

    function automatic logic [7:0] init_pat(input logic [14:0] a);
        if (a == 15'h0012) return 8'hA5;
        return 8'(a * 37) ^ 8'(a >> 8) ^ 8'h5C;
    endfunction

    // Bus-side memory: drives valid data only while mem_read is high.
    logic [7:0] bus_mem [32768];
    logic [7:0] m_rdata;
    assign m_rdata = o_rd ? bus_mem[o_addr[14:0]] : ~bus_mem[o_addr[14:0]];
    assign if0.bus_rdata = m_rdata;
    assign if1.bus_rdata = m_rdata;

    initial begin
        for (int i = 0; i < 32768; i++) bus_mem[i] = init_pat(15'(i));
        forever begin
            @(negedge clk);
            if (o_wr && o_oe) bus_mem[o_addr[14:0]] = o_wdata;
        end
    end

    // Reference memory, updated only by completed transactions.
    logic [7:0] ref_mem [32768];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_xfer(input bit w, input logic [15:0] a, input logic [7:0] d,
                           input bit junk, output int acc);
        int unsigned s, p, h, l;
        logic [31:0] v_rd, v_wr, v_oe, v_rv, v_bz, e_rd, e_wr, e_oe, e_rv, e_bz;
        bit addr_ok, wd_ok;
        logic [7:0] got_rd, exp_rd;
        int n;
        s = 1; p = 2; h = sel ? 0 : 1;
        l = s + p + h + 1;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", o_ready, 1'b1);
        t_valid = 1'b1; t_write = w; t_addr = a; t_wdata = d;
        acc = cyc;
        {v_rd, v_wr, v_oe, v_rv, v_bz} = '0;
        {e_rd, e_wr, e_oe, e_rv, e_bz} = '0;
        addr_ok = 1'b1; wd_ok = 1'b1; got_rd = '0;
        for (int unsigned k = 1; k <= l; k++) begin
            @(negedge clk);
            if (junk && k < l) begin
                t_valid = 1'b1;
                t_write = 1'($urandom_range(1));
                t_addr  = 16'($urandom);
                t_wdata = 8'($urandom);
            end else begin
                t_valid = 1'b0;
            end
            v_rd[k] = o_rd; v_wr[k] = o_wr; v_oe[k] = o_oe;
            v_rv[k] = o_rv; v_bz[k] = o_busy;
            if (o_addr !== a) addr_ok = 1'b0;
            if (o_oe && (o_wdata !== d)) wd_ok = 1'b0;
            e_rd[k] = !w && (k > s) && (k <= s + p);
            e_wr[k] = w && (k > s) && (k <= s + p);
            e_oe[k] = w && (k < l);
            e_rv[k] = (k == l);
            e_bz[k] = 1'b1;
            if (k == l) got_rd = o_rdata;
        end
        if (w) begin
            ref_mem[a[14:0]] = d;
            exp_rd = '0;
        end else begin
            exp_rd = ref_mem[a[14:0]];
        end
        check("mem_read_phase", v_rd, e_rd);
        check("mem_write_phase", v_wr, e_wr);
        check("wdata_oe_phase", v_oe, e_oe);
        check("rsp_valid_phase", v_rv, e_rv);
        check("busy_phase", v_bz, e_bz);
        check("bus_addr_stable", addr_ok, 1'b1);
        check("bus_wdata_value", wd_ok, 1'b1);
        check("rsp_rdata", got_rd, exp_rd);
        if (w) check("mem_contents", bus_mem[a[14:0]], d);
        @(negedge clk);
        check("idle_after", {o_rv, o_ready, o_busy, o_rd, o_wr, o_oe, o_addr, o_rdata},
              {6'b010000, a, exp_rd});
    endtask

    task automatic abort_write(input logic [15:0] a, input logic [7:0] d);
        bit rv_seen;
        t_valid = 1'b1; t_write = 1'b1; t_addr = a; t_wdata = d;
        @(negedge clk);
        t_valid = 1'b0;
        @(negedge clk);
        check("abort_strobe_on", o_wr, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_async", {o_rd, o_wr, o_oe, o_busy, o_rv, o_ready}, 6'b000001);
        @(negedge clk);
        reset = 1'b0;
        rv_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rv_seen |= o_rv;
        end
        check("abort_no_rsp", rv_seen, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc1, acc2;
        logic [15:0] ra;
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_pat(15'(i));

        @(negedge clk);
        check("reset_dut0", {if0.req_ready, if0.rsp_valid, if0.mem_read, if0.mem_write,
              if0.bus_wdata_oe, if0.busy, if0.rsp_rdata, if0.bus_addr, if0.bus_wdata},
              {6'b100000, 32'h0});
        check("reset_dut1", {if1.req_ready, if1.rsp_valid, if1.mem_read, if1.mem_write,
              if1.bus_wdata_oe, if1.busy, if1.rsp_rdata, if1.bus_addr, if1.bus_wdata},
              {6'b100000, 32'h0});
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_reset", {o_ready, o_busy, o_rv, o_rd, o_wr, o_oe}, 6'b100000);

        for (int unsigned pass = 0; pass < 2; pass++) begin
            sel = 1'(pass);
            @(negedge clk);
            do_xfer(1'b0, 16'h0012, 8'h00, 1'b0, acc1);
            do_xfer(1'b1, 16'h7FFF, 8'h3C, 1'b0, acc1);
            do_xfer(1'b0, 16'h8005, 8'hFF, 1'b0, acc1);
            do_xfer(1'b1, 16'h0100, 8'h11 + 8'(pass), 1'b1, acc1);
            do_xfer(1'b0, 16'h0100, 8'h00, 1'b0, acc2);
            check("b2b_spacing", 64'(acc2 - acc1), sel ? 64'd5 : 64'd6);
            abort_write(16'h0200, 8'h77);
            do_xfer(1'b0, 16'h7FFF, 8'h00, 1'b0, acc1);
            for (int i = 0; i < (pass == 0 ? 25 : 12); i++) begin
                ra = 16'($urandom);
                if (ra[14:0] == 15'h0200) ra[0] = 1'b1;
                do_xfer(1'($urandom_range(1)), ra, 8'($urandom),
                        1'($urandom_range(1)), acc1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Bus-cycle initiator that drives the relay computer's 32 KB memory over the shared address, data and control buses.
- Accepts single read/write requests from the sequencer through a valid/ready handshake.
- Sequences each request through relay-style timing phases: address setup, strobe, hold.
- For reads, captures the memory's read data and returns it with a one-cycle response pulse.

Parameters:
- SETUP_CYC, 1: cycles address (and write data) are stable before strobe; legal range 1-15.
- STROBE_CYC, 2: cycles mem_read/mem_write are asserted; legal range 1-15.
- HOLD_CYC, 1: cycles address (and write data) are held after strobe deasserts; legal range 0-15.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  16  byte address; bit 15 is passed through, and memory ignores it.
- req_wdata  input  8  write data.
- req_ready  output  1  initiator can accept a request.
- rsp_valid  output  1  one-cycle pulse: read data valid, or write complete.
- rsp_rdata  output  8  captured read data; 0 for writes.
- bus_addr  output  16  address bus drive.
- mem_read  output  1  read strobe; memory drives the data bus while high.
- mem_write  output  1  write strobe; memory samples the data bus while high.
- bus_wdata  output  8  data driven toward memory.
- bus_wdata_oe  output  1  tri-state enable for bus_wdata onto the data bus.
- bus_rdata  input  8  data bus as seen by the initiator.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - State is IDLE.
  - req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0.
  - bus_addr = 0, bus_wdata = 0, bus_wdata_oe = 0.
  - mem_read = 0, mem_write = 0.
  - busy = 0.
  - The phase counter is cleared.
  - Reset mid-cycle aborts the transfer: strobes drop in the same instant and no rsp_valid is issued.
- States:
  - IDLE: req_ready = 1. On a clk edge with req_valid = 1, latch req_addr, req_write and req_wdata, drive bus_addr, load counter = SETUP_CYC-1, go to SETUP.
  - SETUP: bus_addr stable. For writes, bus_wdata_oe = 1 and bus_wdata = latched data. Counter decrements each cycle. At 0, load STROBE_CYC-1 and go to STROBE.
  - STROBE: mem_read = ~write and mem_write = write; both are registered outputs. For reads, bus_rdata is sampled into rsp_rdata on the last STROBE cycle (counter = 0). At 0: if HOLD_CYC = 0 go to DONE, else load HOLD_CYC-1 and go to HOLD.
  - HOLD: strobes = 0. Address and write data (with oe) are held. At 0, go to DONE.
  - DONE: exactly one cycle. rsp_valid = 1, bus_wdata_oe = 0, strobes = 0. Then go to IDLE.
- req_ready is high only in IDLE, so at most one transfer is outstanding.
- req_valid while busy is ignored, not queued. The requester must hold it until accepted.
- mem_read and mem_write are never high together. An assertion must check this.
- bus_addr keeps its last value in IDLE and only changes when a request is accepted.
- bus_wdata_oe is never 1 during a read transfer.
- Latency from acceptance edge to rsp_valid = SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles. Defaults give 5.
- Back-to-back: a request presented in the cycle after DONE (IDLE) is accepted immediately. Minimum spacing between acceptances = latency + 1.
- rsp_rdata holds its value until the next read captures. A write sets it to 0 at DONE.

Test Plan:
- Reset then idle: all outputs at reset values, req_ready = 1, busy = 0.
- Read at 0x0012 with memory model returning 0xA5 (defaults): mem_read high for exactly 2 cycles, starting 1 cycle after acceptance. rsp_valid pulses 5 cycles after acceptance with rsp_rdata = 0xA5. bus_wdata_oe stays 0 throughout.
- Write 0x3C to 0x7FFF: bus_wdata_oe = 1 from SETUP through HOLD, and bus_wdata = 0x3C. mem_write high 2 cycles. The memory model contains 0x3C at 0x7FFF afterwards. rsp_valid pulses once with rsp_rdata = 0.
- Address 0x8005 read: bus_addr = 0x8005, and the memory model returns the contents of 0x0005.
- Back-to-back write 0x11 at 0x0100, then read 0x0100: the second request is accepted the cycle after the first rsp_valid, and the read returns 0x11. Also drive req_valid during busy: it is ignored, with no extra transfer.
- Assert reset during STROBE of a write: mem_write drops asynchronously, no rsp_valid occurs, and the next request completes normally. Repeat with HOLD_CYC = 0: latency = 4.
